// File: rtl/gate_code_pkg.sv
// Shared definitions for the gate vector decoder: the legal codewords,
// the bit position of each gate output, the FSM states and the buffer entry.
package gate_code_pkg;

  // Legal gate vectors for each operand pair {A,B}
  localparam logic [7:0] CW_00 = 8'hEC;
  localparam logic [7:0] CW_01 = 8'h56;
  localparam logic [7:0] CW_10 = 8'h96;
  localparam logic [7:0] CW_11 = 8'h23;

  // Bit position of each gate output inside the vector
  localparam int BIT_AND   = 0;
  localparam int BIT_OR    = 1;
  localparam int BIT_NAND  = 2;
  localparam int BIT_NOR   = 3;
  localparam int BIT_XOR   = 4;
  localparam int BIT_XNOR  = 5;
  localparam int BIT_NOT_A = 6;
  localparam int BIT_NOT_B = 7;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  typedef struct packed {
    logic err;
    logic a;
    logic b;
  } entry_t;

  // Map a gate vector to its buffer entry; anything that is not one of the
  // four codewords becomes an error entry with both operands forced to 0.
  function automatic entry_t decode_vec(input logic [7:0] vec);
    entry_t e;
    e = '{err: 1'b1, a: 1'b0, b: 1'b0};
    case (vec)
      CW_00:   e = '{err: 1'b0, a: 1'b0, b: 1'b0};
      CW_01:   e = '{err: 1'b0, a: 1'b0, b: 1'b1};
      CW_10:   e = '{err: 1'b0, a: 1'b1, b: 1'b0};
      CW_11:   e = '{err: 1'b0, a: 1'b1, b: 1'b1};
      default: e = '{err: 1'b1, a: 1'b0, b: 1'b0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/gate_dec_fifo.sv
// Two-entry synchronous FIFO holding decoded entries. Slot 0 is always the
// head, so the head value comes straight from a register.
module gate_dec_fifo
  import gate_code_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  entry_t     slot0_r;
  entry_t     slot1_r;
  logic [1:0] count_r;
  logic       do_push_s;
  logic       do_pop_s;

  // Qualify requests: no push into a full buffer (even with a pop), no pop from empty
  always_comb begin
    do_push_s = push & (count_r != 2'd2);
    do_pop_s  = pop & (count_r != 2'd0);
  end

  // Storage and occupancy update; a pop shifts slot 1 into the head slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_r <= '{err: 1'b0, a: 1'b0, b: 1'b0};
      slot1_r <= '{err: 1'b0, a: 1'b0, b: 1'b0};
      count_r <= 2'd0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_r <= din;
          end else begin
            slot1_r <= din;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          slot0_r <= slot1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            slot0_r <= din;
          end else begin
            slot0_r <= slot1_r;
            slot1_r <= din;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Status flags derived from the occupancy register
  always_comb begin
    full  = (count_r == 2'd2);
    empty = (count_r == 2'd0);
    head  = slot0_r;
  end

endmodule

// File: rtl/gate_vector_decoder.sv
// Receive-side decoder for the eight-bit gate vector: recovers {A,B}, flags
// illegal words, counts errors, latches a fault after a run of consecutive
// bad words, and buffers results behind a valid/ready output.
module gate_vector_decoder
  import gate_code_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_vec,
  input  logic             clr_fault,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_err,
  output logic             fault,
  output logic [CNT_W-1:0] err_count
);

  // Consecutive-error counter is 4 bits, enough for a limit of up to 15
  localparam logic [3:0]       LIMIT   = 4'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r;
  logic             fault_r;
  logic [3:0]       consec_r;
  logic [CNT_W-1:0] err_count_r;

  entry_t           dec_s;
  entry_t           head_s;
  logic             full_s;
  logic             empty_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             pop_s;
  logic [3:0]       consec_next_s;

  // Decode the offered word and form the two handshakes
  always_comb begin
    dec_s         = decode_vec(in_vec);
    in_ready_s    = rst_n & (state_r == ST_RUN) & ~full_s;
    accept_s      = in_valid & in_ready_s;
    pop_s         = ~empty_s & out_ready;
    consec_next_s = consec_r + 4'd1;
  end

  gate_dec_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept_s),
    .pop   (pop_s),
    .din   (dec_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // Error counters and RUN/FAULT state; clr_fault overrides any increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      fault_r     <= 1'b0;
      consec_r    <= 4'd0;
      err_count_r <= '0;
    end else if (clr_fault) begin
      state_r     <= ST_RUN;
      fault_r     <= 1'b0;
      consec_r    <= 4'd0;
      err_count_r <= '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (accept_s && dec_s.err) begin
            consec_r <= consec_next_s;
            if (err_count_r != CNT_MAX) begin
              err_count_r <= err_count_r + CNT_W'(1);
            end
            if (consec_next_s == LIMIT) begin
              state_r <= ST_FAULT;
              fault_r <= 1'b1;
            end
          end else if (accept_s) begin
            consec_r <= 4'd0;
          end
        end
        ST_FAULT: begin
          fault_r <= 1'b1;
        end
        default: begin
          state_r <= ST_FAULT;
          fault_r <= 1'b1;
        end
      endcase
    end
  end

  // Drive the ports from the registered state and the buffer head
  always_comb begin
    in_ready  = in_ready_s;
    out_valid = ~empty_s;
    out_a     = head_s.a;
    out_b     = head_s.b;
    out_err   = head_s.err;
    fault     = fault_r;
    err_count = err_count_r;
  end

endmodule
